// File: rtl/serial_subtractor_if.sv
// Handshake and operand/result bundle for the bit-serial subtractor.
// The master side (controller) drives start and the operands; the slave
// side (subtractor) returns busy/done and the registered result.
interface serial_subtractor_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow;

  modport master (
    output start, a, b,
    input  busy, done, diff, borrow
  );

  modport slave (
    input  start, a, b,
    output busy, done, diff, borrow
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: DIFF = A - B, LSB first, one bit per clock.
// A single full-adder cell sees the A bit, the inverted B bit and a carry
// preset to 1, which together form the two's-complement subtraction.
// The final carry-out is inverted to give the unsigned borrow (A < B).
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;

  logic             fa_a, fa_b, fa_s, fa_co;
  logic [WIDTH-1:0] res_shift;

  // Full-adder cell: A bit plus inverted B bit plus running carry
  always_comb begin
    fa_a      = a_q[0];
    fa_b      = ~b_q[0];
    fa_s      = fa_a ^ fa_b ^ carry_q;
    fa_co     = (fa_a & fa_b) | (fa_a & carry_q) | (fa_b & carry_q);
    res_shift = {fa_s, res_q[WIDTH-1:1]};
  end

  // Next-state and datapath control for IDLE -> RUN -> DONE -> IDLE
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          res_d   = '0;
          carry_d = 1'b1;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = {1'b0, a_q[WIDTH-1:1]};
        b_d     = {1'b0, b_q[WIDTH-1:1]};
        res_d   = res_shift;
        carry_d = fa_co;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          // Last bit: publish the completed result and the borrow
          diff_d   = res_shift;
          borrow_d = ~fa_co;
          state_d  = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, shift registers and result; reset clears every partial value
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
    end
  end

  assign bus.busy   = (state_q == RUN);
  assign bus.done   = (state_q == DONE);
  assign bus.diff   = diff_q;
  assign bus.borrow = borrow_q;

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial N-bit subtractor; the inverse operation to the team's gate-level 1-bit full adder.
- Computes DIFF = A - B, LSB first, one bit per clock, using a single full-adder cell with B inverted and carry-in preset to 1 (two's complement).
- Sits beside the ripple adder datapath as a low-area arithmetic unit.
- Start/busy/done handshake for a controlling FSM.

Parameters:
- WIDTH, 4, operand and result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle completion pulse (state DONE).
- diff  output  WIDTH  registered result, A - B mod 2^WIDTH.
- borrow  output  1  registered; 1 when unsigned A < B.

Behaviour:
- Reset:
  - Asynchronous and active-high; takes effect immediately, mid-operation included.
  - State returns to IDLE.
  - busy=0, done=0, diff=0, borrow=0.
  - Internal shift registers, carry and bit counter are cleared.
  - No partial result survives reset.
- FSM states are IDLE, RUN and DONE.
  - IDLE: start=1 at edge k captures a and b into shift registers, sets carry=1 and count=0, and moves to RUN. start=0 keeps IDLE.
  - RUN: at each edge the cell uses ai = LSB of A register and bi = ~(LSB of B register). s = ai^bi^carry; carry' = majority(ai,bi,carry). s shifts into the MSB of the result shift register (shift right). A and B shift right and count increments.
  - RUN → DONE: after WIDTH RUN edges (edges k+1..k+WIDTH). At edge k+WIDTH, diff is loaded from the completed result (including bit WIDTH-1) and borrow = ~carry'.
  - DONE lasts exactly one cycle; done=1. The next edge returns to IDLE unconditionally.
- Latency:
  - start accepted at edge k.
  - busy high from edge k+1 until edge k+WIDTH.
  - done high between edges k+WIDTH and k+WIDTH+1.
  - Total WIDTH+1 cycles from start to done.
  - A new start is accepted in IDLE at edge k+WIDTH+2 at the earliest.
- busy = (state==RUN); done = (state==DONE). Both decode directly from the state register (glitch-free).
- start is ignored while in RUN or DONE; it is not queued.
- a and b may change freely after capture without effect.
- diff and borrow change only at the RUN→DONE edge or on reset. They hold their value through IDLE and the next RUN.
- A=B gives diff=0, borrow=0. Wrap-around is mod 2^WIDTH, with no saturation.

Test Plan (WIDTH=4):
- a=9, b=3, start pulse → done WIDTH+1=5 cycles later, diff=6, borrow=0; busy high exactly 4 cycles.
- a=3, b=9 → diff=4'b1010 (10), borrow=1.
- a=5, b=5 → diff=0, borrow=0. Then a=0, b=15 → diff=1, borrow=1. Back-to-back with start held high: the second op is accepted in IDLE immediately after DONE.
- Hold start high and change a/b during RUN (first op a=12, b=4) → only one op completes, diff=8, borrow=0. No second done occurs before IDLE is re-entered.
- Assert rst on the 2nd RUN cycle of a=7, b=2 → immediately busy=0, done=0, diff=0, borrow=0, no done pulse. After release, a fresh a=7, b=2 gives diff=5.
- Exhaustive sweep over all 256 (a,b) pairs → diff == (a-b)&15 and borrow == (a<b) for every pair; diff holds its value between operations.
